clasificador_cafe_multi: RTL and testbench

CLASIFICADOR_CAFE_MULTI -- requirements
Module: clasificador_cafe_multi

---
 rtl/clasif_pkg.sv | 13 +
 rtl/sensor_estable.sv | 27 ++
 rtl/clasificador_cafe_multi.sv | 111 +++++++++++
 tb/tb_clasificador_cafe_multi.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/clasif_pkg.sv
// clasif_pkg: grade/state enums, grade encodings and the score-to-grade rule
// shared by the coffee-bean classifier.
package clasif_pkg;
   typedef enum logic [1:0] {NONE = 2'b00, BAJA = 2'b01, MEDIA = 2'b10, ALTA = 2'b11} grade_t;
   typedef enum logic [1:0] {IDLE, SAMPLE, DECIDE, HOLD} state_t;
   localparam logic [1:0] GRADE_NONE  = 2'b00;
   localparam logic [1:0] GRADE_BAJA  = 2'b01;
   localparam logic [1:0] GRADE_MEDIA = 2'b10;
   localparam logic [1:0] GRADE_ALTA  = 2'b11;
   function automatic grade_t classify(input int score, input int n);
      return score == n ? ALTA : score >= (n + 1) / 2 ? MEDIA : BAJA;
   endfunction
endpackage

// File: rtl/sensor_estable.sv
// sensor_estable: flags a sensor vector that has held for STABLE_CYCLES
// consecutive identical samples; vec is the last registered sample.
module sensor_estable #(
   parameter int W             = 3,
   parameter int STABLE_CYCLES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic         stable,
   output logic [W-1:0] vec
);
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] S_MAX = CW'(STABLE_CYCLES);
   logic [CW-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         vec <= '0;
      end else begin
         vec <= d;
         cnt <= (clr || d != vec) ? '0 : cnt == S_MAX ? cnt : cnt + 1'b1;
      end
   end
   assign stable = !clr && cnt == S_MAX;
endmodule

// File: rtl/clasificador_cafe_multi.sv
// clasificador_cafe_multi: grades a bean from NUM_SENSORS pass/fail sensors.
// Grade counters exist only when CLASIF_STATS_EN is defined.
module clasificador_cafe_multi
   import clasif_pkg::*;
#(
   parameter int NUM_SENSORS    = 3,
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ena,
   input  logic                   bean_present,
   input  logic [NUM_SENSORS-1:0] sensor_in,
   input  logic                   grade_ready,
   output logic                   grade_valid,
   output logic [1:0]             grade,
   output logic                   led_baja,
   output logic                   led_media,
   output logic                   led_alta,
   output logic                   timeout_err,
   output logic                   busy,
   output logic [CNT_W-1:0]       cnt_baja,
   output logic [CNT_W-1:0]       cnt_media,
   output logic [CNT_W-1:0]       cnt_alta
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   state_t state, state_n;
   grade_t grade_q;
   logic bean_q, armed, rise, stable, timeout, hs, forced;
   logic [TW-1:0] tcnt;
   logic [NUM_SENSORS-1:0] vec, vec_q;

   sensor_estable #(.W(NUM_SENSORS), .STABLE_CYCLES(STABLE_CYCLES)) u_estable (
      .clk(clk), .rst_n(rst_n), .clr(state != SAMPLE), .d(sensor_in), .stable(stable), .vec(vec)
   );

   // armed stays low after reset until bean_present is seen low, so a bean
   // already present at reset release cannot start a measurement
   assign rise        = ena && armed && bean_present && !bean_q;
   assign timeout     = tcnt == TW'(TIMEOUT_CYCLES - 1);
   assign grade_valid = state == HOLD;
   assign hs          = grade_valid && grade_ready;
   assign grade       = grade_valid ? grade_q : GRADE_NONE;
   assign busy        = state != IDLE;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = rise ? SAMPLE : IDLE;
         SAMPLE:  state_n = (stable || timeout) ? DECIDE : SAMPLE;
         DECIDE:  state_n = HOLD;
         default: state_n = grade_ready ? IDLE : HOLD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         bean_q      <= 1'b0;
         armed       <= 1'b0;
         tcnt        <= '0;
         timeout_err <= 1'b0;
         vec_q       <= '0;
         forced      <= 1'b0;
         grade_q     <= NONE;
         led_baja    <= 1'b0;
         led_media   <= 1'b0;
         led_alta    <= 1'b0;
      end else begin
         state       <= state_n;
         bean_q      <= bean_present;
         armed       <= armed || !bean_present;
         tcnt        <= state == SAMPLE ? tcnt + 1'b1 : '0;
         timeout_err <= state == SAMPLE && !stable && timeout;
         if (state == SAMPLE && (stable || timeout)) begin
            vec_q  <= stable ? vec : sensor_in;
            forced <= !stable;
         end
         if (state == DECIDE) grade_q <= forced ? BAJA : classify($countones(vec_q), NUM_SENSORS);
         if (hs) begin
            led_baja  <= grade_q == BAJA;
            led_media <= grade_q == MEDIA;
            led_alta  <= grade_q == ALTA;
         end
      end
   end

`ifdef CLASIF_STATS_EN
   logic [CNT_W-1:0] cb, cm, ca;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cb <= '0;
         cm <= '0;
         ca <= '0;
      end else if (hs) begin
         if (grade_q == BAJA && !(&cb)) cb <= cb + 1'b1;
         if (grade_q == MEDIA && !(&cm)) cm <= cm + 1'b1;
         if (grade_q == ALTA && !(&ca)) ca <= ca + 1'b1;
      end
   end
   assign cnt_baja  = cb;
   assign cnt_media = cm;
   assign cnt_alta  = ca;
`else
   assign cnt_baja  = '0;
   assign cnt_media = '0;
   assign cnt_alta  = '0;
`endif
endmodule

// File: tb/tb_clasificador_cafe_multi.sv
// tb_clasificador_cafe_multi: scoreboard bench for the bean classifier,
// run with CNT_W=2 so counter saturation is reachable.
module tb_clasificador_cafe_multi;
`ifdef CLASIF_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   logic clk = 1'b0, rst_n, ena, bean_present, grade_ready;
   logic [2:0] sensor_in;
   logic grade_valid, led_baja, led_media, led_alta, timeout_err, busy;
   logic [1:0] grade, cnt_baja, cnt_media, cnt_alta;
   int checks = 0, errors = 0;
   logic [1:0] exp_q[$];
   logic [2:0] exp_leds = 3'b000;
   int exp_cnt[3] = '{0, 0, 0};

   clasificador_cafe_multi #(.NUM_SENSORS(3), .STABLE_CYCLES(4), .TIMEOUT_CYCLES(64), .CNT_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .bean_present(bean_present), .sensor_in(sensor_in),
      .grade_ready(grade_ready), .grade_valid(grade_valid), .grade(grade), .led_baja(led_baja),
      .led_media(led_media), .led_alta(led_alta), .timeout_err(timeout_err), .busy(busy),
      .cnt_baja(cnt_baja), .cnt_media(cnt_media), .cnt_alta(cnt_alta)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] model_grade(input logic [2:0] s);
      int c = int'(s[0]) + int'(s[1]) + int'(s[2]);
      return c == 3 ? 2'b11 : c >= 2 ? 2'b10 : 2'b01;
   endfunction

   task automatic check_stats(input string tag);
      check({tag, "_leds"}, {led_baja, led_media, led_alta}, exp_leds);
      check({tag, "_cnt_baja"}, cnt_baja, STATS ? exp_cnt[0] : 0);
      check({tag, "_cnt_media"}, cnt_media, STATS ? exp_cnt[1] : 0);
      check({tag, "_cnt_alta"}, cnt_alta, STATS ? exp_cnt[2] : 0);
   endtask

   // one bean: tog toggles sensor bit 0 every 2 cycles (forces timeout),
   // rd holds grade_ready low for rd cycles, drop lowers ena mid-measurement
   task automatic run_bean(input string tag, input logic [2:0] s, input bit tog, input int rd, input bit drop);
      int n = 0, tpulses = 0, tpos = 0;
      logic [1:0] g;
      sensor_in = s;
      grade_ready = (rd == 0);
      @(negedge clk);
      bean_present = 1'b1;
      exp_q.push_back(tog ? 2'b01 : model_grade(s));
      while (!grade_valid && n < 200) begin
         @(negedge clk);
         n++;
         if (tog && n % 2 == 0) sensor_in = sensor_in ^ 3'b001;
         if (timeout_err) begin
            tpulses++;
            tpos = n;
         end
         if (drop && n == 2) ena = 1'b0;
         if (n == 3) check({tag, "_grade_while_invalid"}, grade, 2'b00);
      end
      if (!grade_valid) begin
         check({tag, "_grade_valid_wait"}, 0, 1);
         return;
      end
      g = exp_q.pop_front();
      check({tag, "_grade"}, grade, g);
      check({tag, "_latency"}, n, tog ? 66 : 7);
      check({tag, "_timeout_pulses"}, tpulses, tog ? 1 : 0);
      if (tog) check({tag, "_timeout_pos"}, tpos, 65);
      for (int i = 1; i <= rd; i++) begin
         @(negedge clk);
         if (i == 1) bean_present = 1'b0;
         if (i == 3) bean_present = 1'b1;
         check({tag, "_hold_valid"}, grade_valid, 1'b1);
         check({tag, "_hold_grade"}, grade, g);
         check({tag, "_hold_leds"}, {led_baja, led_media, led_alta}, exp_leds);
      end
      grade_ready = 1'b1;
      @(negedge clk);
      exp_leds = g == 2'b01 ? 3'b100 : g == 2'b10 ? 3'b010 : 3'b001;
      exp_cnt[g - 1] = exp_cnt[g - 1] == 3 ? 3 : exp_cnt[g - 1] + 1;
      check({tag, "_valid_after_hs"}, grade_valid, 1'b0);
      check({tag, "_grade_after_hs"}, grade, 2'b00);
      check_stats(tag);
      bean_present = 1'b0;
      ena = 1'b1;
      repeat (3) @(negedge clk);
      check({tag, "_idle_busy"}, busy, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      ena = 1'b1;
      bean_present = 1'b0;
      sensor_in = 3'b000;
      grade_ready = 1'b1;
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_valid", grade_valid, 1'b0);
      check("rst_grade", grade, 2'b00);
      check("rst_timeout", timeout_err, 1'b0);
      check_stats("rst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_bean("alta", 3'b111, 0, 0, 0);
      run_bean("media101", 3'b101, 0, 0, 0);
      run_bean("baja100", 3'b100, 0, 0, 0);
      run_bean("media011", 3'b011, 0, 0, 0);
      run_bean("baja000", 3'b000, 0, 0, 0);
      run_bean("timeout", 3'b111, 1, 0, 0);
      run_bean("backpressure", 3'b110, 0, 10, 0);
      ena = 1'b0;
      sensor_in = 3'b111;
      @(negedge clk);
      bean_present = 1'b1;
      repeat (10) @(negedge clk);
      check("ena_low_dropped", busy, 1'b0);
      bean_present = 1'b0;
      ena = 1'b1;
      @(negedge clk);
      run_bean("ena_drop", 3'b111, 0, 0, 1);
      @(negedge clk);
      bean_present = 1'b1;
      repeat (3) @(negedge clk);
      check("mid_sample_busy", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      exp_leds = 3'b000;
      exp_cnt = '{0, 0, 0};
      check("async_rst_busy", busy, 1'b0);
      check("async_rst_valid", grade_valid, 1'b0);
      check("async_rst_grade", grade, 2'b00);
      check("async_rst_timeout", timeout_err, 1'b0);
      check_stats("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check("held_bean_no_start", busy, 1'b0);
      bean_present = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 5; i++) run_bean("sat_alta", 3'b111, 0, 0, 0);
      check("sat_cnt_alta", cnt_alta, STATS ? 2'd3 : 2'd0);
      check("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
